// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W  : data word width
//   BE_W    : number of byte lanes per word
//   ADDR_W  : byte-address width
//   BYTE_W  : width of one byte lane
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x DATA_W storage with one shared read/write port.
// Writes are byte-enabled and synchronous; reads are synchronous and the read
// word stays in o_rdata until the next read. Contents are not reset.
// Ports:
//   i_clk   : clock
//   i_en    : port access this edge
//   i_we    : 1 = write, 0 = read
//   i_be    : byte enables for writes
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the MEM-stage load/store interface.
// Accepts one request at a time, waits LATENCY cycles, performs the access
// on the commit edge and presents the response until it is consumed.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. The responder holds rsp_valid/rsp_rdata/rsp_err stable until
// rsp_ready; req_* inputs are only looked at while req_ready is high.
//
// Optional feature macro: DMEM_ERR_EN -- misaligned or out-of-range
// addresses return rsp_err = 1 with no memory access. Without it, addr[1:0]
// is ignored and out-of-range addresses wrap.
//
// Ports:
//   clock, reset          : clock, async active-high reset
//   req_valid/req_ready   : request handshake
//   req_write/be/addr/wdata : request payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : response payload (rdata is 0 for stores/errors)
//   o_dbg_state           : current FSM state (debug)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BE_W-1:0]   req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_write;
  logic [BE_W-1:0]    r_be;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_rsp_err;
  logic               r_rsp_load;
  logic               w_accept;
  logic               w_commit;
  logic               w_err;
  logic [DATA_W-1:0]  w_arr_rdata;

`ifdef DMEM_ERR_EN
  // Depth is a power of two, so "addr >= DEPTH_WORDS*4" is any upper bit set.
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[ADDR_W-1:IDX_W+2] != '0);
`else
  assign w_err = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = ^{r_addr[ADDR_W-1:IDX_W+2], r_addr[1:0]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_be    <= req_be;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_rsp_err  <= w_err;
        r_rsp_load <= ~r_write & ~w_err;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .i_clk   (clock),
    .i_en    (w_commit & ~w_err),
    .i_we    (r_write),
    .i_be    (r_be),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The array read register only changes on a load commit, so gating it with
  // the registered "last response was a load" flag keeps rsp_rdata stable
  // through RESP and forces 0 for stores, errors and after reset.
  assign rsp_rdata   = r_rsp_load ? w_arr_rdata : '0;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_err     = r_rsp_err;
  assign req_ready   = (r_state == IDLE) & ~reset;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  // Reference memory: one word per index, addressed as (addr/4) mod DEPTH.
  logic [31:0] model_mem [DEPTH];
  // Scoreboard entries are {err, rdata}.
  logic [32:0] exp_q[$];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_be      (req_be),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] model_access(input logic wr, input logic [3:0] be,
                                               input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned idx;
    logic err;
    idx = (addr / 4) % DEPTH;
    err = 1'b0;
`ifdef DMEM_ERR_EN
    err = ((addr % 4) != 0) || (addr >= DEPTH * 4);
`endif
    if (err) return {1'b1, 32'h0};
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end
      return {1'b0, 32'h0};
    end
    return {1'b0, model_mem[idx]};
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) chk_eq("accept_timeout", 32'(req_ready), 32'd1);
  endtask

  // One full transaction; hold = cycles rsp_ready stays low during RESP.
  task automatic do_txn(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] got_rdata, output logic got_err);
    int lat;
    logic [32:0] exp;
    logic [31:0] first_rd;
    exp_q.push_back(model_access(wr, be, addr, wdata));
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    wait_ready();
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk_eq("rsp_latency", 32'(lat), 32'(LAT + 1));
    first_rd  = rsp_rdata;
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int h = 0; h < hold; h++) begin
      chk_eq("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk_eq("bp_rdata_stable", rsp_rdata, first_rd);
      chk_eq("bp_req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk_eq("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk_eq("ready_after_rsp", 32'(req_ready), 32'd1);
    exp = exp_q.pop_front();
    chk_eq("rsp_rdata", got_rdata, exp[31:0]);
    chk_eq("rsp_err", 32'(got_err), 32'(exp[32]));
  endtask

  // Accept a store, then raise reset in cycle c<rc> after the accept cycle.
  task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wdata, input int rc);
    logic [32:0] dummy;
    // The store survives only if reset comes after its commit edge (end of c<LAT>).
    if (rc > LAT) dummy = model_access(1'b1, 4'hF, addr, wdata);
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_be    = 4'hF;
    req_addr  = addr;
    req_wdata = wdata;
    wait_ready();
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k < rc; k++) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_eq("rst_req_ready_low", 32'(req_ready), 32'd0);
    chk_eq("rst_rsp_valid_low", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rdata_zero", rsp_rdata, 32'd0);
    @(negedge clock);
    chk_eq("rst_state_idle", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    #1;
    chk_eq("rst_release_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      chk_eq("rst_no_response", 32'(rsp_valid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = 4'h0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_eq("reset_req_ready", 32'(req_ready), 32'd0);
    chk_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clock);
    chk_eq("ready_after_release", 32'(req_ready), 32'd1);

    // Preload words 0..15 so every later load reads known data.
    for (int i = 0; i < 16; i++) do_txn(1'b1, 4'hF, 32'(i * 4), $urandom, 0, rd, er);

    // Store then load.
    do_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, er);
    do_txn(1'b0, 4'h0, 32'h10, 32'h0, 0, rd, er);
    chk_eq("store_load_const", rd, 32'hDEADBEEF);

    // Byte-enable merge.
    do_txn(1'b1, 4'hF, 32'h20, 32'h11223344, 0, rd, er);
    do_txn(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, rd, er);
    do_txn(1'b0, 4'h0, 32'h20, 32'h0, 0, rd, er);
    chk_eq("be_merge_const", rd, 32'h11BB33DD);

    // Zero byte-enable store changes nothing but still responds.
    do_txn(1'b1, 4'b0000, 32'h20, 32'h55555555, 0, rd, er);
    do_txn(1'b0, 4'h0, 32'h20, 32'h0, 0, rd, er);

    // Back-pressure for 5 cycles.
    do_txn(1'b0, 4'h0, 32'h10, 32'h0, 5, rd, er);

    // Wrap (default) / out-of-range error (DMEM_ERR_EN).
    do_txn(1'b1, 4'hF, 32'h400, 32'hCAFEF00D, 0, rd, er);
    do_txn(1'b0, 4'h0, 32'h0, 32'h0, 0, rd, er);
`ifndef DMEM_ERR_EN
    chk_eq("wrap_const", rd, 32'hCAFEF00D);
`else
    do_txn(1'b1, 4'hF, 32'h402, 32'h12345678, 0, rd, er);
    chk_eq("err_store_flag", 32'(er), 32'd1);
    chk_eq("err_store_rdata", rd, 32'd0);
    do_txn(1'b0, 4'h0, 32'h400, 32'h0, 0, rd, er);
    chk_eq("err_load_flag", 32'(er), 32'd1);
    do_txn(1'b0, 4'h0, 32'h0, 32'h0, 0, rd, er);
`endif

    // Reset mid-WAIT drops the store; reset in RESP keeps the committed store.
    reset_during_store(32'h30, 32'h0BADF00D, 2);
    do_txn(1'b0, 4'h0, 32'h30, 32'h0, 0, rd, er);
    reset_during_store(32'h34, 32'h600DCAFE, LAT + 1);
    do_txn(1'b0, 4'h0, 32'h34, 32'h0, 0, rd, er);

    // Randomized traffic over the preloaded region, with aliases/misalignment.
    for (int t = 0; t < 60; t++) begin
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 2) * DEPTH * 4);
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
             $urandom_range(0, 3), rd, er);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the data-memory load/store interface used by the MEM stage. It accepts one load or store request at a time over a valid/ready handshake and holds it for a fixed, parameterised access latency. It then commits the store or fetches the load word, and returns a response over a second valid/ready handshake. It replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic memory timing and back-pressure.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 2: wait cycles between request acceptance and response; ≥ 1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_be  in  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored for loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  access error; constant 0 unless DMEM_ERR_EN.

## Operation
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: latency countdown.
  - RESP: rsp_valid = 1.
- IDLE: on req_valid & req_ready, capture write, be, addr and wdata, load cnt = LATENCY-1, then go to WAIT.
- WAIT:
  - If cnt ≠ 0, decrement cnt.
  - If cnt = 0, perform the access on this edge and go to RESP.
    - Store: bytes with be = 1 are written.
    - Load: word registered into rsp_rdata.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
- req_ready = (state == IDLE) & ~reset. Requests are never accepted outside IDLE; req_* inputs are ignored there.
- Word index = req_addr[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are dropped, so the index wraps modulo DEPTH_WORDS.
- Store with be = 4'b0000: no bytes change; a response is still returned.
- Memory contents are not reset; the initial content is X.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0. req_ready is 0 while reset is high and 1 in the first cycle after release.
- If the accept handshake is in cycle c0, then:
  - WAIT occupies cycles c1 through cLATENCY.
  - rsp_valid is first high in cycle c(LATENCY+1).
  - The next accept can occur in cycle c(LATENCY+2) at the earliest, with rsp_ready held high.
- Minimum spacing between requests: LATENCY+2 cycles.
- A store is visible to a load accepted in any later cycle.
- Back-pressure: rsp_valid stays high for as long as rsp_ready is low; no timeout.
- Reset asserted mid-operation: the pending request is discarded and no response is issued.
  - A store is lost if reset rises before its commit edge.
  - A store already committed remains in memory.

## Configuration
- DMEM_ERR_EN defined:
  - A request with req_addr[1:0] ≠ 0, or with req_addr ≥ DEPTH_WORDS*4, is an error.
  - On its commit edge there is no memory access; rsp_err = 1 and rsp_rdata = 0.
  - Latency and handshake are unchanged.
- DMEM_ERR_EN undefined: rsp_err is tied to 0, addr[1:0] is ignored, and out-of-range addresses wrap.

## Structure
- Package dmem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - DATA_W = 32, BE_W = 4 and ADDR_W = 32;
  - the byte-lane width constant.
- Sub-module dmem_array: DEPTH_WORDS×32 storage with synchronous byte-enabled write and synchronous registered read. It has one read/write port driven by the responder FSM.
- The FSM, counter and response registers live in dmem_responder.

## Test plan
- Store then load: store addr 0x10, be 4'hF, wdata 0xDEADBEEF, then load 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0. rsp_valid rises exactly LATENCY+1 cycles after each accept.
- Byte enables: preload 0x11223344 at 0x20, store be 4'b0101 with wdata 0xAABBCCDD, then load → 0x11BB33DD.
- Back-pressure: hold rsp_ready low for 5 cycles during RESP → rsp_valid/rsp_rdata stay stable and req_ready stays 0. After rsp_ready rises, req_ready is 1 in the following cycle.
- Wrap: with DEPTH_WORDS = 256 and DMEM_ERR_EN undefined, store 0xCAFEF00D at 0x400, then load 0x0 → 0xCAFEF00D.
- Error (DMEM_ERR_EN): store to 0x402 → rsp_err 1, rsp_rdata 0, memory unchanged; load 0x400 → rsp_err 1.
- Reset mid-WAIT: with LATENCY = 4, accept a store to 0x30, then assert reset in c2 → no response, and a later load of 0x30 returns the old value. req_ready is 0 during reset and 1 after release.
